// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl
//   Programmable clock divider front end. It produces a divided clock
//   (clk_out) and a one-cycle strobe (tick) at each clk_out rising edge.
//   A new divisor can be offered at any time over a valid/ready handshake.
//   A new divisor or an enable change only takes effect on a period
//   boundary, so clk_out never produces a runt pulse.
//
// Ports
//   clk_in      : system clock
//   reset       : asynchronous reset, active low
//   enable      : 1 = run; 0 = stop at the next period boundary
//   cfg_valid   : a new divisor is offered on cfg_div
//   cfg_div     : requested divisor N (values below 2 are clamped to 2)
//   cfg_ready   : controller can accept a new divisor
//   clk_out     : divided clock, high for the first N - floor(N/2) phases
//   tick        : one-cycle pulse at each clk_out rising edge
//   busy        : 1 while the divider is running
//   div_active  : divisor currently in use
module clk_div_ctrl #(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] div_active
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] div_active_q, div_active_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;

    // Number of high phases per period: the odd extra phase goes to the high half.
    logic [CNT_W-1:0] high_len;
    // Next phase index, one bit wider so the "+1" cannot wrap.
    logic [CNT_W:0]   cnt_inc;
    logic             at_boundary;
    logic             xfer;

    assign high_len    = div_active_q - (div_active_q >> 1);
    assign cnt_inc     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign at_boundary = (cnt_q == div_active_q - CNT_W'(1));

    // The pending slot holds a single value; while it is full, offers are ignored.
    assign cfg_ready   = ~pend_vld_q;
    assign xfer        = cfg_valid & cfg_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        clk_out_d    = clk_out_q;
        tick_d       = 1'b0;
        div_active_d = div_active_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
                // Nothing is being divided, so a pending value can be applied right away.
                if (pend_vld_q) begin
                    div_active_d = pend_q;
                    pend_vld_d   = 1'b0;
                end
                if (enable) begin
                    state_d   = RUN;
                    clk_out_d = 1'b1;
                    tick_d    = 1'b1;
                end
            end

            RUN: begin
                if (at_boundary) begin
                    // Swap divisors only between periods.
                    if (pend_vld_q) begin
                        div_active_d = pend_q;
                        pend_vld_d   = 1'b0;
                    end
                    cnt_d = '0;
                    if (enable) begin
                        clk_out_d = 1'b1;
                        tick_d    = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        clk_out_d = 1'b0;
                    end
                end else begin
                    cnt_d     = cnt_inc[CNT_W-1:0];
                    clk_out_d = (cnt_inc < {1'b0, high_len});
                end
            end

            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                clk_out_d = 1'b0;
            end
        endcase

        // A value accepted on this edge sees pend_vld_q == 0 above, so it is
        // never applied on the same edge; it waits for the next boundary.
        if (xfer) begin
            pend_d     = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
            div_active_q <= DIV_RST;
            pend_q       <= DIV_RST;
            pend_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
            div_active_q <= div_active_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
        end
    end

    assign clk_out    = clk_out_q;
    assign tick       = tick_q;
    assign busy       = (state_q == RUN);
    assign div_active = div_active_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

    localparam int CNT_W = 16;
    localparam int DEF_N = 2;

    logic             clk_in;
    logic             reset;
    logic             enable;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             clk_out;
    logic             tick;
    logic             busy;
    logic [CNT_W-1:0] div_active;

    int n_tests = 0;
    int n_fail  = 0;

    clk_div_ctrl #(.CNT_W(CNT_W), .DIV_DEFAULT(DEF_N)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy),
        .div_active(div_active)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the divider is either running or not, sits at some
    // phase of an N-cycle period, and may hold one pending divisor.
    bit m_run;
    int m_ph;
    int m_n;
    bit m_pv;
    int m_pend;

    always @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            m_run = 0; m_ph = 0; m_n = DEF_N; m_pv = 0; m_pend = 0;
        end else begin
            bit take;
            take = cfg_valid && !m_pv;
            if (!m_run) begin
                if (m_pv) begin m_n = m_pend; m_pv = 0; end
                if (enable) begin m_run = 1; m_ph = 0; end
            end else if (m_ph == m_n - 1) begin
                if (m_pv) begin m_n = m_pend; m_pv = 0; end
                m_ph = 0;
                if (!enable) m_run = 0;
            end else begin
                m_ph++;
            end
            if (take) begin
                m_pend = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
                m_pv   = 1;
            end
        end
    end

    // Continuous comparison against the model while out of reset.
    bit cmp_en = 0;
    always @(negedge clk_in) begin
        if (cmp_en && reset) begin
            chk("m_clk_out",    int'(clk_out),    int'(m_run && (m_ph < m_n - m_n / 2)));
            chk("m_tick",       int'(tick),       int'(m_run && m_ph == 0));
            chk("m_busy",       int'(busy),       int'(m_run));
            chk("m_cfg_ready",  int'(cfg_ready),  int'(!m_pv));
            chk("m_div_active", int'(div_active), m_n);
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 40) begin
            @(negedge clk_in);
            k++;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    // Program a divisor while idle: offer for one edge, applied on the next.
    task automatic prog_idle(input int n);
        cfg_valid = 1; cfg_div = CNT_W'(n);
        @(negedge clk_in);
        cfg_valid = 0;
        @(negedge clk_in);
    endtask

    initial begin
        int e1[6]  = '{1, 0, 1, 0, 1, 0};
        int t1[6]  = '{1, 0, 1, 0, 1, 0};
        int e2[10] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
        int t2[10] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        int e3[10] = '{1, 1, 0, 0, 1, 1, 0, 1, 1, 0};
        int e4[9]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
        int b4[9]  = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
        int t4[9]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};

        reset = 0; enable = 0; cfg_valid = 0; cfg_div = '0;
        repeat (3) @(negedge clk_in);
        chk("rst_clk_out", int'(clk_out), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_div_active", int'(div_active), 2);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        reset = 1;
        cmp_en = 1;
        @(negedge clk_in);

        // 1: default divide-by-2.
        enable = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            chk("t1_clk_out", int'(clk_out), e1[i]);
            chk("t1_tick", int'(tick), t1[i]);
        end
        chk("t1_div_active", int'(div_active), 2);
        chk("t1_cfg_ready", int'(cfg_ready), 1);
        enable = 0;
        wait_idle();

        // 2: program 5 while idle.
        cfg_valid = 1; cfg_div = 5;
        @(negedge clk_in);
        cfg_valid = 0;
        chk("t2_ready_low", int'(cfg_ready), 0);
        @(negedge clk_in);
        chk("t2_ready_back", int'(cfg_ready), 1);
        chk("t2_div_active", int'(div_active), 5);
        enable = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            chk("t2_clk_out", int'(clk_out), e2[i]);
            chk("t2_tick", int'(tick), t2[i]);
        end
        enable = 0;
        wait_idle();

        // 3: running at 4, switch to 3 at phase 1.
        prog_idle(4);
        enable = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            if (i == 1) begin cfg_valid = 1; cfg_div = 3; end
            if (i == 2) cfg_valid = 0;
            chk("t3_clk_out", int'(clk_out), e3[i]);
            if (i == 2 || i == 3) begin
                chk("t3_ready_low", int'(cfg_ready), 0);
                chk("t3_div_old", int'(div_active), 4);
            end
            if (i == 4) begin
                chk("t3_ready_back", int'(cfg_ready), 1);
                chk("t3_div_new", int'(div_active), 3);
            end
        end
        enable = 0;
        wait_idle();

        // 4: running at 6, drop enable at phase 2.
        prog_idle(6);
        enable = 1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_in);
            if (i == 2) enable = 0;
            chk("t4_clk_out", int'(clk_out), e4[i]);
            chk("t4_busy", int'(busy), b4[i]);
            chk("t4_tick", int'(tick), t4[i]);
        end

        // 5: clamping, and offers ignored while not ready.
        prog_idle(9);
        prog_idle(0);
        chk("t5_clamp0", int'(div_active), 2);
        prog_idle(9);
        prog_idle(1);
        chk("t5_clamp1", int'(div_active), 2);
        cfg_valid = 1; cfg_div = 7;
        @(negedge clk_in);
        chk("t5_ready_low", int'(cfg_ready), 0);
        cfg_div = 9;
        @(negedge clk_in);
        cfg_valid = 0;
        chk("t5_div7", int'(div_active), 7);
        @(negedge clk_in);
        chk("t5_ignored", int'(div_active), 7);

        // 6: reset at phase 3 of N=7 with a value pending.
        enable = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            if (i == 2) begin cfg_valid = 1; cfg_div = 3; end
            if (i == 3) cfg_valid = 0;
        end
        chk("t6_pending", int'(cfg_ready), 0);
        chk("t6_clk_hi", int'(clk_out), 1);
        #2 reset = 0;
        #1;
        chk("t6_async_clk_out", int'(clk_out), 0);
        chk("t6_async_tick", int'(tick), 0);
        chk("t6_async_busy", int'(busy), 0);
        enable = 0;
        @(negedge clk_in);
        reset = 1;
        @(negedge clk_in);
        chk("t6_div_default", int'(div_active), DEF_N);
        chk("t6_cfg_ready", int'(cfg_ready), 1);
        chk("t6_idle", int'(busy), 0);
        chk("t6_clk_low", int'(clk_out), 0);

        // Randomized traffic, checked by the model process.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_in);
            enable    = ($urandom_range(0, 9) < 7);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_div   = CNT_W'($urandom_range(0, 9));
            if ($urandom_range(0, 499) == 0) begin
                #1 reset = 0;
                #2 reset = 1;
            end
        end

        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
